// File: rtl/ayar_pkg.sv
// Shared field indices, controller state and field-mask helper for the clock set-mode controller.
package ayar_pkg;

  localparam int N_ALAN = 6;

  localparam logic [2:0] ALAN_SANIYE = 3'd0;
  localparam logic [2:0] ALAN_DAKIKA = 3'd1;
  localparam logic [2:0] ALAN_SAAT   = 3'd2;
  localparam logic [2:0] ALAN_GUN    = 3'd3;
  localparam logic [2:0] ALAN_AY     = 3'd4;
  localparam logic [2:0] ALAN_YIL    = 3'd5;

  typedef enum logic {
    CALIS,
    DUZENLE
  } durum_e;

  function automatic logic [N_ALAN-1:0] alan_maskesi(input logic [2:0] alan);
    return N_ALAN'(1) << alan;
  endfunction

endpackage

// File: rtl/ayar_kontrol_buton_filtre.sv
// Button conditioner: 2-FF sync, symmetric debounce, arm-after-release, press pulse and
// optional auto-repeat while the debounced level stays high.
module buton_filtre #(
  parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYC = 50_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 10_000_000,
  parameter bit          REPEAT_EN        = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic ham_i,
  input  logic iptal_i,
  output logic seviye_o,
  output logic olay_o
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                       : REPEAT_RATE_CYC;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DEB_TAM = DW'(DEBOUNCE_CYC);

  logic          sync1_q, sync2_q, son_q;
  logic [DW-1:0] run_q, run_d;
  logic          seviye_q, seviye_d;
  logic          silahli_q, silahli_d;
  logic          olay_q, olay_d;
  logic          tekrar_q, tekrar_d;
  logic          faz_q, faz_d;
  logic [RW-1:0] tcnt_q, tcnt_d;
  logic          kararli, basma, ates;
  logic [RW-1:0] limit;

  always_comb begin
    run_d = run_q;
    if (sync2_q != son_q) run_d = DW'(1);
    else if (run_q != DEB_TAM) run_d = run_q + DW'(1);
    kararli   = (run_d == DEB_TAM);
    seviye_d  = kararli ? sync2_q : seviye_q;
    // Arming needs a confirmed-low run, so a button held through reset stays silent.
    silahli_d = silahli_q | (kararli & ~sync2_q);
    basma     = silahli_q & seviye_d & ~seviye_q;

    limit    = faz_q ? RW'(REPEAT_RATE_CYC - 1) : RW'(REPEAT_DELAY_CYC - 1);
    tekrar_d = tekrar_q;
    faz_d    = faz_q;
    tcnt_d   = tcnt_q;
    ates     = 1'b0;
    if (basma) begin
      tekrar_d = REPEAT_EN;
      faz_d    = 1'b0;
      tcnt_d   = '0;
    end else if (!seviye_d || iptal_i) begin
      tekrar_d = 1'b0;
      faz_d    = 1'b0;
      tcnt_d   = '0;
    end else if (tekrar_q) begin
      if (tcnt_q == limit) begin
        ates   = 1'b1;
        faz_d  = 1'b1;
        tcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + RW'(1);
      end
    end
    olay_d = basma | ates;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      son_q     <= 1'b0;
      run_q     <= '0;
      seviye_q  <= 1'b0;
      silahli_q <= 1'b0;
      olay_q    <= 1'b0;
      tekrar_q  <= 1'b0;
      faz_q     <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      sync1_q   <= ham_i;
      sync2_q   <= sync1_q;
      son_q     <= sync2_q;
      run_q     <= run_d;
      seviye_q  <= seviye_d;
      silahli_q <= silahli_d;
      olay_q    <= olay_d;
      tekrar_q  <= tekrar_d;
      faz_q     <= faz_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign seviye_o = seviye_q;
  assign olay_o   = olay_q;

endmodule

// File: rtl/ayar_kontrol.sv
// Set-mode controller: forwards field carries in run mode, turns buttons into per-field
// increment/decrement strobes in edit mode. duzenleme mirrors the FSM state.
module ayar_kontrol
  import ayar_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYC = 50_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 10_000_000,
  parameter int unsigned BLINK_CYC        = 25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_mod,
  input  logic              btn_arttir,
  input  logic              btn_azalt,
  input  logic [N_ALAN-1:0] tasma,
  output logic [N_ALAN-1:0] arttir,
  output logic [N_ALAN-1:0] azalt,
  output logic              stop,
  output logic              duzenleme,
  output logic [2:0]        secili_alan,
  output logic              blink,
  output logic              saniye_sifirla
);

  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  logic mod_olay, art_olay, az_olay, art_sev, az_sev, mod_seviye_unused;
  logic ikisi, iptal;

  durum_e            durum_q, durum_d;
  logic [2:0]        alan_q, alan_d;
  logic [N_ALAN-1:0] arttir_q, arttir_d, azalt_q, azalt_d;
  logic              blink_q, blink_d, sifirla_q, sifirla_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;

  // Both levels high blocks strobes; it and any mode event also kill pending repeats.
  assign ikisi = art_sev & az_sev;
  assign iptal = ikisi | mod_olay;

  buton_filtre #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
    .REPEAT_RATE_CYC(REPEAT_RATE_CYC), .REPEAT_EN(1'b0)
  ) u_mod (
    .clk(clk), .reset(reset), .ham_i(btn_mod), .iptal_i(1'b0),
    .seviye_o(mod_seviye_unused), .olay_o(mod_olay)
  );

  buton_filtre #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
    .REPEAT_RATE_CYC(REPEAT_RATE_CYC), .REPEAT_EN(1'b1)
  ) u_arttir (
    .clk(clk), .reset(reset), .ham_i(btn_arttir), .iptal_i(iptal),
    .seviye_o(art_sev), .olay_o(art_olay)
  );

  buton_filtre #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
    .REPEAT_RATE_CYC(REPEAT_RATE_CYC), .REPEAT_EN(1'b1)
  ) u_azalt (
    .clk(clk), .reset(reset), .ham_i(btn_azalt), .iptal_i(iptal),
    .seviye_o(az_sev), .olay_o(az_olay)
  );

  always_comb begin
    durum_d   = durum_q;
    alan_d    = alan_q;
    arttir_d  = '0;
    azalt_d   = '0;
    sifirla_d = 1'b0;
    blink_d   = blink_q;
    bcnt_d    = bcnt_q;
    case (durum_q)
      CALIS: begin
        arttir_d = tasma;
        blink_d  = 1'b0;
        bcnt_d   = '0;
        if (mod_olay) begin
          durum_d = DUZENLE;
          alan_d  = ALAN_SANIYE;
          blink_d = 1'b1;
        end
      end
      DUZENLE: begin
        if (mod_olay) begin
          bcnt_d = '0;
          if (alan_q == ALAN_YIL) begin
            durum_d   = CALIS;
            alan_d    = ALAN_SANIYE;
            sifirla_d = 1'b1;
            blink_d   = 1'b0;
          end else begin
            alan_d  = alan_q + 3'd1;
            blink_d = 1'b1;
          end
        end else begin
          if (!ikisi) begin
            if (art_olay)     arttir_d = alan_maskesi(alan_q);
            else if (az_olay) azalt_d  = alan_maskesi(alan_q);
          end
          if (bcnt_q == BW'(BLINK_CYC - 1)) begin
            blink_d = ~blink_q;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      durum_q   <= CALIS;
      alan_q    <= ALAN_SANIYE;
      arttir_q  <= '0;
      azalt_q   <= '0;
      blink_q   <= 1'b0;
      bcnt_q    <= '0;
      sifirla_q <= 1'b0;
    end else begin
      durum_q   <= durum_d;
      alan_q    <= alan_d;
      arttir_q  <= arttir_d;
      azalt_q   <= azalt_d;
      blink_q   <= blink_d;
      bcnt_q    <= bcnt_d;
      sifirla_q <= sifirla_d;
    end
  end

  assign arttir         = arttir_q;
  assign azalt          = azalt_q;
  assign duzenleme      = (durum_q == DUZENLE);
  assign stop           = duzenleme;
  assign secili_alan    = alan_q;
  assign blink          = blink_q;
  assign saniye_sifirla = sifirla_q;

endmodule
